// File: rtl/add16.sv
// Registered 16-bit ripple-carry adder; optional carry/overflow flags under ADD16_FLAGS_EN.
// Latency: 1 clk, one operand pair accepted every cycle.
// Backpressure: none; no handshake and no stall.
module add16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
`ifdef ADD16_FLAGS_EN
    ,
    output logic        carry,
    output logic        overflow
`endif
);

    // c[i] is the carry into bit i; bit 0 is a half adder, so its carry-in is implicitly 0
    logic [15:0] sum;
    logic [15:1] c;

    assign sum[0] = a[0] ^ b[0];
    assign c[1]   = a[0] & b[0];

    for (genvar i = 1; i < 15; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign sum[15] = a[15] ^ b[15] ^ c[15];

`ifdef ADD16_FLAGS_EN
    logic cout15;
    logic ovf;

    assign cout15 = (a[15] & b[15]) | (c[15] & (a[15] ^ b[15]));
    assign ovf    = (a[15] == b[15]) && (sum[15] != a[15]);

    always_ff @(posedge clk) begin
        if (reset) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            carry    <= cout15;
            overflow <= ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= 16'h0000;
        end else begin
            out <= sum;
        end
    end

endmodule

// File: tb/tb_add16.sv
// Random and directed bench for add16 against an arithmetic reference model.
module tb_add16;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
`ifdef ADD16_FLAGS_EN
    logic        carry;
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    add16 dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .out      (out)
`ifdef ADD16_FLAGS_EN
        ,
        .carry    (carry),
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain 17-bit integer sum of the operands seen at each edge
    logic [15:0] m_out;
    logic        m_c;
    logic        m_v;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_out   = 16'h0000;
            m_c     = 1'b0;
            m_v     = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            {m_c, m_out} = {1'b0, a} + {1'b0, b};
            m_v = ($signed(a) + $signed(b) > 32767) || ($signed(a) + $signed(b) < -32768);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // checked mid-cycle so input glitches between edges would be caught
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out", out, m_out);
`ifdef ADD16_FLAGS_EN
            chk("model_carry", {15'b0, carry}, {15'b0, m_c});
            chk("model_ovf", {15'b0, overflow}, {15'b0, m_v});
`endif
        end
    end

    task automatic step(input logic rst, input logic [15:0] ia, input logic [15:0] ib);
        @(negedge clk);
        reset = rst;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [15:0] eo, input logic ec, input logic ev);
        chk(name, out, eo);
`ifdef ADD16_FLAGS_EN
        chk({name, "_carry"}, {15'b0, carry}, {15'b0, ec});
        chk({name, "_ovf"}, {15'b0, overflow}, {15'b0, ev});
`else
        if (ec === 1'bx || ev === 1'bx) $display("unused flag expectation");
`endif
    endtask

    initial begin
        reset = 1'b0;
        a     = 16'h0;
        b     = 16'h0;

        step(1'b1, 16'h1234, 16'h1111);
        lit("reset_out", 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0001, 16'h1080);
        lit("add_1081", 16'h1081, 1'b0, 1'b0);
        step(1'b0, 16'h0001, 16'h0001);
        lit("b2b_0002", 16'h0002, 1'b0, 1'b0);
        step(1'b0, 16'hA211, 16'h0730);
        lit("b2b_a941", 16'hA941, 1'b0, 1'b0);
        step(1'b0, 16'h8001, 16'h8003);
        lit("neg_wrap", 16'h0004, 1'b1, 1'b1);
        step(1'b0, 16'h0001, 16'hFFFB);
        lit("minus4", 16'hFFFC, 1'b0, 1'b0);
        step(1'b0, 16'hFFFF, 16'h0001);
        lit("wrap_zero", 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h7FFF, 16'h0001);
        lit("reset_mid", 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h7FFF, 16'h0001);
        lit("pos_ovf", 16'h8000, 1'b0, 1'b1);
        step(1'b0, 16'hFFFF, 16'hFFFF);
        lit("all_ones", 16'hFFFE, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) == 0), 16'($urandom), 16'($urandom));
            // glitch the operands between edges; out must not follow
            #1;
            a = 16'($urandom);
            b = 16'($urandom);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add16.md
ADD16 -- requirements
Module: add16

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  16  first addend, two's-complement or unsigned (same bit pattern).
REQ-005 b  input  16  second addend, two's-complement or unsigned (same bit pattern).
REQ-006 out  output  16  registered sum a+b modulo 2^16.
REQ-007 With ADD16_FLAGS_EN defined, the block SHALL add: carry  output  1  unsigned carry-out of bit 15, registered.
REQ-008 With ADD16_FLAGS_EN defined, the block SHALL add: overflow  output  1  signed overflow, registered.

Function
REQ-009 Sum SHALL be computed structurally as a 16-stage ripple-carry chain: half-adder at bit 0, full-adders at bits 1-15, carry-in of bit 0 fixed at 0.
REQ-010 Each full-adder: sum = x XOR y XOR cin; cout = (x AND y) OR (cin AND (x XOR y)).
REQ-011 On every rising clk edge with reset low, out SHALL load the 16-bit sum of the a and b values sampled at that edge.
REQ-012 Latency SHALL be exactly 1 clock: out reflects the inputs present at the previous rising edge.
REQ-013 Throughput SHALL be one new operand pair per clock; no handshake, no stall.
REQ-014 Width rule: result SHALL wrap modulo 2^16; carry-out of bit 15 SHALL be discarded from out.
REQ-015 Signed and unsigned interpretation SHALL yield the same bit pattern; no saturation.
REQ-016 overflow SHALL be 1 exactly when a[15]==b[15] and sum[15]!=a[15].
REQ-017 Inputs changing between edges SHALL have no effect on out until the next rising edge.
REQ-018 The full combinational path a/b -> sum register SHALL close timing within one clk period; no internal pipelining.

Reset
REQ-019 When reset is high at a rising clk edge, out SHALL become 16'h0000, regardless of a and b.
REQ-020 When ADD16_FLAGS_EN is defined, the same reset SHALL clear carry and overflow to 0.
REQ-021 Reset SHALL take priority over the add; the first valid sum SHALL appear at the first rising edge after reset deasserts.
REQ-022 Before the first reset, output values SHALL be unspecified.

Configuration
REQ-023 Macro ADD16_FLAGS_EN SHALL control the status flags.
REQ-024 With ADD16_FLAGS_EN defined, carry and overflow ports and their registers SHALL exist and follow REQ-007, REQ-008, REQ-016 and REQ-020.
REQ-025 Without ADD16_FLAGS_EN, carry and overflow ports SHALL be absent and the carry-out of bit 15 SHALL be left unused.
REQ-026 In both configurations, out SHALL be bit-identical.

Verification
REQ-027 Reset with a=16'h1234, b=16'h1111 -> out=16'h0000 after the edge; flags=0.
REQ-028 a=16'h0001, b=16'h1080 -> out=16'h1081 one clock later (carry=0, overflow=0).
REQ-029 a=16'h0001, b=16'h0001, then a=16'hA211, b=16'h0730 on consecutive clocks -> out=16'h0002, then 16'hA941 (back-to-back, 1-cycle latency).
REQ-030 a=16'h8001, b=16'h8003 -> out=16'h0004; carry=1, overflow=1 (-32767 + -32765 wraps to 4).
REQ-031 a=16'h0001, b=16'hFFFB (1 + -5) -> out=16'hFFFC (-4); carry=0, overflow=0.
REQ-032 a=16'hFFFF, b=16'h0001 -> out=16'h0000, carry=1, overflow=0; then assert reset mid-stream with a=16'h7FFF, b=16'h0001 -> out=16'h0000, not 16'h8000.
